// File: rtl/decrypt_run_controller_pkg.sv
// Shared types and constants for the decryption run sequencer.
// The char buffer lives at a fixed RAM window; the helpers keep address math in one place.
package decrypt_run_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PAD  = 3'd2,
    S_CFG  = 3'd3,
    S_EXEC = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_e;

  localparam logic [1:0]  PROG_EN  = 2'b01;
  localparam logic [1:0]  PROG_BF  = 2'b10;
  localparam logic [11:0] BUF_BASE = 12'd1500;
  localparam logic [6:0]  BUF_LEN  = 7'd108;

  function automatic logic prog_legal(input logic [1:0] prog);
    return (prog == PROG_EN) || (prog == PROG_BF);
  endfunction

  // Wraps silently at 12 bits; with BUF_LEN=108 the top entry is 1607.
  function automatic logic [11:0] buf_addr(input logic [6:0] idx);
    return BUF_BASE + {5'd0, idx};
  endfunction

endpackage

// File: rtl/decrypt_run_controller_if.sv
// Board-I/O and processor-wrapper signals of the run sequencer.
// slave = controller view, master = environment (board I/O + wrapper) view.
interface decrypt_run_controller_if;
  logic        start;
  logic        abort;
  logic [1:0]  prog_in;
  logic [4:0]  shift_in;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        cpu_done;
  logic        ram_wen;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_own;
  logic        r6_wen;
  logic [31:0] r6_data;
  logic        cpu_run;
  logic [1:0]  program_sel;
  logic [7:0]  char_count;
  logic        done;
  logic        error;

  modport slave (
    input  start, abort, prog_in, shift_in, char_valid, char_data, cpu_done,
    output char_ready, ram_wen, ram_addr, ram_wdata, ram_own, r6_wen, r6_data,
           cpu_run, program_sel, char_count, done, error
  );

  modport master (
    output start, abort, prog_in, shift_in, char_valid, char_data, cpu_done,
    input  char_ready, ram_wen, ram_addr, ram_wdata, ram_own, r6_wen, r6_data,
           cpu_run, program_sel, char_count, done, error
  );
endinterface

// File: rtl/decrypt_run_controller_watchdog.sv
// EXEC-phase watchdog: counts enabled cycles from zero, flags the last allowed one.
module decrypt_run_controller_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 10000000,
  parameter int unsigned TMR_W       = 24
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_CYC - 32'd1);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Next count: saturates at LIMIT so a stalled FSM never wraps back to zero.
  always_comb begin
    if (clear) begin
      cnt_d = {TMR_W{1'b0}};
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + {{(TMR_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= {TMR_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/decrypt_run_controller.sv
// Run sequencer: loads and zero-pads the char buffer, programs r6, runs the CPU under a watchdog.
// Outputs are flops loaded from next-state values, so they line up with the state they describe.
module decrypt_run_controller
  import decrypt_run_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 10000000,
  parameter int unsigned TMR_W       = 24
) (
  input  logic                     clock,
  input  logic                     reset,
  decrypt_run_controller_if.slave  bus
);

  state_e      state_q, state_d;
  logic [6:0]  idx_q, idx_d;
  logic [7:0]  count_q, count_d;
  logic [1:0]  prog_q, prog_d;
  logic [4:0]  shift_q, shift_d;

  logic        wr_en_s;
  logic [11:0] wr_addr_s;
  logic [7:0]  wr_data_s;
  logic        accept_s;
  logic        wd_clear_s;
  logic        wd_en_s;
  logic        expired_s;

  logic        char_ready_q, char_ready_d;
  logic        ram_wen_q, ram_wen_d;
  logic [11:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic        ram_own_q, ram_own_d;
  logic        r6_wen_q, r6_wen_d;
  logic        cpu_run_q, cpu_run_d;
  logic [1:0]  program_sel_q, program_sel_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  assign accept_s   = bus.char_valid && char_ready_q;
  assign wd_en_s    = (state_q == S_EXEC);
  assign wd_clear_s = (state_q != S_EXEC);

  decrypt_run_controller_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMR_W       (TMR_W)
  ) u_run_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear_s),
    .enable  (wd_en_s),
    .expired (expired_s)
  );

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      idx_q         <= 7'd0;
      count_q       <= 8'd0;
      prog_q        <= 2'b00;
      shift_q       <= 5'd0;
      char_ready_q  <= 1'b0;
      ram_wen_q     <= 1'b0;
      ram_addr_q    <= 12'd0;
      ram_wdata_q   <= 8'd0;
      ram_own_q     <= 1'b0;
      r6_wen_q      <= 1'b0;
      cpu_run_q     <= 1'b0;
      program_sel_q <= 2'b00;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      count_q       <= count_d;
      prog_q        <= prog_d;
      shift_q       <= shift_d;
      char_ready_q  <= char_ready_d;
      ram_wen_q     <= ram_wen_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      ram_own_q     <= ram_own_d;
      r6_wen_q      <= r6_wen_d;
      cpu_run_q     <= cpu_run_d;
      program_sel_q <= program_sel_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  // Next state and buffer writer. idx==BUF_LEN in LOAD/PAD is the drain cycle:
  // the final write is on the bus and CFG follows, so r6 is written strictly after it.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    prog_d    = prog_q;
    shift_d   = shift_q;
    wr_en_s   = 1'b0;
    wr_addr_s = 12'd0;
    wr_data_s = 8'd0;
    if (bus.abort) begin
      state_d = S_IDLE;
      idx_d   = 7'd0;
      count_d = 8'd0;
      prog_d  = 2'b00;
      shift_d = 5'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start && prog_legal(bus.prog_in)) begin
            state_d = S_LOAD;
            prog_d  = bus.prog_in;
            shift_d = bus.shift_in;
            count_d = 8'd0;
            idx_d   = 7'd0;
          end else if (bus.start) begin
            state_d = S_ERR;
          end else begin
            state_d = state_q;
          end
        end
        S_LOAD: begin
          if (idx_q == BUF_LEN) begin
            state_d = S_CFG;
          end else if (accept_s && (bus.char_data == 8'h00)) begin
            state_d = S_PAD;
          end else if (accept_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = buf_addr(idx_q);
            wr_data_s = bus.char_data;
            idx_d     = idx_q + 7'd1;
            count_d   = count_q + 8'd1;
          end else begin
            state_d = S_LOAD;
          end
        end
        S_PAD: begin
          if (idx_q == BUF_LEN) begin
            state_d = S_CFG;
          end else begin
            wr_en_s   = 1'b1;
            wr_addr_s = buf_addr(idx_q);
            idx_d     = idx_q + 7'd1;
          end
        end
        S_CFG: begin
          state_d = S_EXEC;
        end
        S_EXEC: begin
          if (bus.cpu_done) begin
            state_d = S_DONE;
          end else if (expired_s) begin
            state_d = S_ERR;
          end else begin
            state_d = S_EXEC;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state.
  always_comb begin
    char_ready_d = (state_d == S_LOAD) && (idx_d < BUF_LEN);
    ram_own_d    = (state_d == S_LOAD) || (state_d == S_PAD);
    r6_wen_d     = (state_d == S_CFG);
    cpu_run_d    = (state_d == S_EXEC);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
    ram_wen_d    = wr_en_s;
    ram_addr_d   = wr_addr_s;
    ram_wdata_d  = wr_data_s;
    if ((state_d == S_EXEC) || (state_d == S_DONE)) begin
      program_sel_d = prog_d;
    end else begin
      program_sel_d = 2'b00;
    end
  end

  assign bus.char_ready  = char_ready_q;
  assign bus.ram_wen     = ram_wen_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = {24'd0, ram_wdata_q};
  assign bus.ram_own     = ram_own_q;
  assign bus.r6_wen      = r6_wen_q;
  assign bus.r6_data     = {27'd0, shift_q};
  assign bus.cpu_run     = cpu_run_q;
  assign bus.program_sel = program_sel_q;
  assign bus.char_count  = count_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_decrypt_run_controller.sv
// Bench for decrypt_run_controller: start-handling table, hand-written corner runs,
// and randomized runs checked against a transaction-level buffer/exec model.
module tb_decrypt_run_controller;

  localparam int TO = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  decrypt_run_controller_if bus();

  decrypt_run_controller #(.TIMEOUT_CYC(TO), .TMR_W(24)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Write monitor plus bus-level invariants.
  logic [11:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  int   hi_bad  = 0;
  int   own_bad = 0;
  int   lat_bad = 0;
  logic prev_wen = 1'b0;
  logic prev_r6  = 1'b0;

  always @(negedge clock) begin
    if (bus.ram_wen) begin
      wq_addr.push_back(bus.ram_addr);
      wq_data.push_back(bus.ram_wdata[7:0]);
      if (bus.ram_wdata[31:8] != 24'd0) hi_bad <= hi_bad + 1;
      if (!bus.ram_own) own_bad <= own_bad + 1;
    end
    if (bus.r6_wen && (!prev_wen || prev_r6)) lat_bad <= lat_bad + 1;
    prev_wen <= bus.ram_wen;
    prev_r6  <= bus.r6_wen;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

  logic [7:0] txt [0:119];
  logic       blocked;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {31'd0, |{bus.char_ready, bus.ram_wen, bus.ram_addr, bus.ram_wdata, bus.ram_own,
                          bus.r6_wen, bus.r6_data, bus.cpu_run, bus.program_sel, bus.char_count,
                          bus.done, bus.error}}, 32'd0);
  endtask

  // One full run: n bytes from txt (terminator added when n < 108), then EXEC ending with
  // cpu_done in run cycle done_at (1..16) or a watchdog expiry (done_at = 0).
  task automatic do_run(input logic [1:0] prog, input logic [4:0] sh, input int n,
                        input int done_at, input bit gaps);
    int base, exp_n, bad, runc, k;
    logic [7:0]  exp_b;
    logic [11:0] exp_a;
    base    = wq_addr.size();
    exp_n   = (n > 108) ? 108 : n;
    blocked = 1'b0;
    bus.prog_in = prog; bus.shift_in = sh; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("start_to_load", {31'd0, bus.char_ready}, 32'd1);
    check("count_cleared", {24'd0, bus.char_count}, 32'd0);
    check("done_error_cleared", {30'd0, bus.done, bus.error}, 32'd0);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) repeat ($urandom_range(0, 1)) step();
      if (!bus.char_ready) begin
        blocked = 1'b1;
        break;
      end
      bus.char_valid = 1'b1; bus.char_data = txt[i];
      step();
      bus.char_valid = 1'b0;
      if (i == 0) check("accept_to_write", {19'd0, bus.ram_wen, bus.ram_addr}, {19'd0, 1'b1, 12'd1500});
    end
    if (n < 108) begin
      bus.char_valid = 1'b1; bus.char_data = 8'h00;
      step();
      bus.char_valid = 1'b0;
    end else begin
      bus.char_valid = 1'b1; bus.char_data = 8'hAA;
    end
    k = 0;
    while (!bus.r6_wen && k < 300) begin
      step();
      k++;
    end
    bus.char_valid = 1'b0;
    check("r6_wen_seen", {31'd0, bus.r6_wen}, 32'd1);
    check("r6_data", bus.r6_data, {27'd0, sh});
    check("char_count", {24'd0, bus.char_count}, exp_n);
    check("ram_own_dropped", {31'd0, bus.ram_own}, 32'd0);
    check("write_count", wq_addr.size() - base, 32'd108);
    if (wq_addr.size() > base) check("last_write_addr", {20'd0, wq_addr[wq_addr.size() - 1]}, 32'd1607);
    bad = 0;
    for (int i = 0; i < 108 && (base + i) < wq_addr.size(); i++) begin
      exp_b = (i < exp_n) ? txt[i] : 8'h00;
      exp_a = 12'(1500 + i);
      if (wq_addr[base + i] != exp_a || wq_data[base + i] != exp_b) bad++;
    end
    check("buffer_image", bad, 32'd0);
    step();
    check("cpu_run_rise", {31'd0, bus.cpu_run}, 32'd1);
    check("program_sel_exec", {30'd0, bus.program_sel}, {30'd0, prog});
    runc = 1;
    while (bus.cpu_run && runc < 40) begin
      if (runc == done_at) bus.cpu_done = 1'b1;
      step();
      bus.cpu_done = 1'b0;
      if (bus.cpu_run) runc++;
    end
    if (done_at >= 1 && done_at <= TO) begin
      check("exec_cycles_done", runc, done_at);
      check("done_level", {30'd0, bus.done, bus.error}, 32'd2);
      check("program_sel_done", {30'd0, bus.program_sel}, {30'd0, prog});
    end else begin
      check("exec_cycles_timeout", runc, TO);
      check("error_level", {30'd0, bus.done, bus.error}, 32'd1);
      check("program_sel_err", {30'd0, bus.program_sel}, 32'd0);
    end
  endtask

  typedef struct {
    logic       ab;
    logic [1:0] prog;
    logic [4:0] sh;
    logic       exp_ready;
    logic       exp_error;
    logic [4:0] exp_r6;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int k;
    tbl[0] = '{1'b0, 2'b00, 5'd5,  1'b0, 1'b1, 5'd0};
    tbl[1] = '{1'b0, 2'b01, 5'd7,  1'b1, 1'b0, 5'd7};
    tbl[2] = '{1'b0, 2'b10, 5'd31, 1'b1, 1'b0, 5'd31};
    tbl[3] = '{1'b0, 2'b11, 5'd2,  1'b0, 1'b1, 5'd0};
    tbl[4] = '{1'b1, 2'b01, 5'd9,  1'b0, 1'b0, 5'd0};
    tbl[5] = '{1'b0, 2'b10, 5'd0,  1'b1, 1'b0, 5'd0};

    bus.start = 1'b0; bus.abort = 1'b0; bus.prog_in = 2'b00; bus.shift_in = 5'd0;
    bus.char_valid = 1'b0; bus.char_data = 8'h00; bus.cpu_done = 1'b0;
    #1;
    check_zero("reset_outputs");
    step(); step();
    reset = 1'b1;
    step();
    check_zero("idle_after_reset");

    // Start handling from a freshly aborted (IDLE) controller.
    for (int i = 0; i < 6; i++) begin
      bus.abort = 1'b1;
      step();
      bus.abort = tbl[i].ab; bus.prog_in = tbl[i].prog; bus.shift_in = tbl[i].sh; bus.start = 1'b1;
      step();
      bus.start = 1'b0; bus.abort = 1'b0;
      check("tbl_char_ready", {31'd0, bus.char_ready}, {31'd0, tbl[i].exp_ready});
      check("tbl_error", {31'd0, bus.error}, {31'd0, tbl[i].exp_error});
      check("tbl_r6_data", bus.r6_data, {27'd0, tbl[i].exp_r6});
      check("tbl_program_sel", {30'd0, bus.program_sel}, 32'd0);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;

    // "HI" run, then a new BF run from DONE must clear done and the count.
    txt[0] = 8'h48; txt[1] = 8'h49;
    do_run(2'b01, 5'd3, 2, 5, 1'b0);
    for (int i = 0; i < 5; i++) txt[i] = 8'(8'h61 + i);
    do_run(2'b10, 5'd17, 5, 0, 1'b1);

    // Full buffer without terminator; 109th byte must be refused.
    for (int i = 0; i < 120; i++) txt[i] = 8'($urandom_range(1, 255));
    do_run(2'b10, 5'd9, 109, 0, 1'b0);
    check("full_blocks_109th", {31'd0, blocked}, 32'd1);
    do_run(2'b01, 5'd1, 10, TO, 1'b1);

    // cpu_done outside EXEC is ignored.
    bus.cpu_done = 1'b1;
    step();
    bus.cpu_done = 1'b0;
    check("cpu_done_ignored", {30'd0, bus.done, bus.error}, 32'd2);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 120; i++) txt[i] = 8'($urandom_range(1, 255));
      do_run(($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, 5'($urandom_range(0, 31)),
             $urandom_range(0, 112), $urandom_range(0, TO), 1'b1);
    end

    // Abort while padding, then an illegal program request.
    bus.prog_in = 2'b01; bus.shift_in = 5'd4; bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.char_valid = 1'b1; bus.char_data = 8'h00;
    step();
    bus.char_valid = 1'b0;
    repeat (5) step();
    check("pad_writing", {31'd0, bus.ram_wen}, 32'd1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_zero("abort_in_pad");
    bus.prog_in = 2'b11; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("illegal_prog_err", {30'd0, bus.error, bus.char_ready}, 32'd2);

    // Reset in the middle of EXEC.
    bus.prog_in = 2'b01; bus.shift_in = 5'd3; bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.char_valid = 1'b1; bus.char_data = 8'h00;
    step();
    bus.char_valid = 1'b0;
    k = 0;
    while (!bus.r6_wen && k < 300) begin
      step();
      k++;
    end
    step();
    repeat (3) step();
    check("exec_before_reset", {31'd0, bus.cpu_run}, 32'd1);
    #2 reset = 1'b0;
    #1 check_zero("reset_async_exec");
    step();
    check_zero("reset_edge_exec");
    reset = 1'b1;
    step();
    check_zero("idle_after_exec_reset");

    check("wdata_upper_zero", hi_bad, 32'd0);
    check("ram_own_during_write", own_bad, 32'd0);
    check("r6_after_last_write", lat_bad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
